ladybird_bus_responder: RTL

Memory-side responder for the ladybird core's instruction and data buses: accepts one request at a time over a valid/ready request channel, applies writes to or reads from an internal word-addressed RAM, and returns a response over a valid/ready response channel after a programmable number of wait states. It is the secondary end of the bus the core's MMU drives as primary. It serves as the simulation/FPGA memory behind `i_bus` and `d_bus`, with one instance per bus.

---
 rtl/ladybird_bus_responder.sv | 97 +++++++++
 1 files changed

// File: rtl/ladybird_bus_responder.sv
// Word-addressed RAM responder for one ladybird bus: single outstanding request, programmable wait states.
// Optional out-of-range error reporting via LADYBIRD_BUS_RESPONDER_RANGE_CHECK_EN.
module ladybird_bus_responder #(
   parameter int              XLEN        = 32,
   parameter int              DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] BASE_ADDR   = '0,
   parameter int              LATENCY     = 1
) (
   input  logic              clk,
   input  logic              anrst,
   input  logic              nrst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [XLEN-1:0]   req_addr,
   input  logic              req_we,
   input  logic [XLEN/8-1:0] req_strb,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err
);
   localparam int         IW       = $clog2(DEPTH_WORDS);
   localparam int         NB       = XLEN / 8;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            err;
   } resp_t;

   state_t          state;
   logic [3:0]      cnt;
   resp_t           rsp_q;
   logic [XLEN-1:0] mem [DEPTH_WORDS];

   logic [XLEN-1:0] offs;
   logic [IW-1:0]   idx;
   logic            range_err;
   logic            accept;
   logic            wr_en;
   logic            unused_bits;

   assign offs = req_addr - BASE_ADDR;
   assign idx  = offs[IW+1:2];

`ifdef LADYBIRD_BUS_RESPONDER_RANGE_CHECK_EN
   assign range_err   = (offs[XLEN-1:IW+2] != '0);
   assign unused_bits = ^offs[1:0];
`else
   // Upper offset bits are discarded so accesses alias modulo the RAM depth.
   assign range_err   = 1'b0;
   assign unused_bits = ^{offs[XLEN-1:IW+2], offs[1:0]};
`endif

   assign accept = (state == IDLE) && req_valid;
   // Writes commit at the acceptance edge; held-off while either reset is asserted.
   assign wr_en  = accept && req_we && !range_err && nrst && anrst;

   always_ff @(posedge clk) begin
      for (int b = 0; b < NB; b++)
         if (wr_en && req_strb[b]) mem[idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
   end

   always_ff @(posedge clk or negedge anrst) begin
      if (!anrst) begin
         state <= IDLE;
         cnt   <= '0;
         rsp_q <= '0;
      end else if (!nrst) begin
         state <= IDLE;
         cnt   <= '0;
         rsp_q <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               // Read data is captured now, so a later write cannot leak into it.
               rsp_q.data <= (req_we || range_err) ? '0 : mem[idx];
               rsp_q.err  <= range_err;
               cnt        <= CNT_INIT;
               state      <= (LATENCY > 0) ? WAIT : RESP;
            end
            WAIT: if (cnt == '0) state <= RESP;
                  else           cnt   <= cnt - 4'd1;
            RESP: if (resp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign resp_data  = rsp_q.data;
   assign resp_err   = rsp_q.err;
endmodule
